booth_control: RTL
==================

Name: booth_control

Overview:
Sequencer for the signed radix-2 Booth multiplier. It sits after the input reader.
- It takes the debounced operands and the 500 ms start level, then captures the operands once per press.
- It runs N add/subtract-and-shift iterations on an internal accumulator.
- It publishes the 2N-bit signed product with a sticky done flag for the display stage.

Parameters:
N, 8, operand width in bits (two's complement); product is 2N bits.

Ports:
CLK100MHZ  input  1  system clock, 100 MHz; all state updates on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted); one clock; reset is asynchronous and active-low.
start  input  1  level request (driven by pb_salida); only a 0->1 transition starts an operation.
multiplicador  input  N  signed multiplier Q, sampled only in LOAD.
multiplicando  input  N  signed multiplicand M, sampled only in LOAD.
producto  output  2N  signed product, registered, held until the next completion.
listo  output  1  done flag, sticky, high from completion until the next accepted start.
ocupado  output  1  high while state is not IDLE.
estado  output  3  current state encoding, for debug LEDs.

Behaviour:
- Reset values (async, reset=0):
  - State IDLE.
  - producto=0, listo=0, ocupado=0.
  - A=0, Q=0, Q_1=0, M=0, contador=0.
  - start_q=1, so a start already high at reset release does not trigger.
- Edge detect: start_q <= start every cycle; rise = start & ~start_q.
- State encoding: IDLE=0, LOAD=1, EVAL=2, SHIFT=3, DONE=4. Unused codes go to IDLE on the next edge.
- IDLE: if rise, go to LOAD; otherwise stay.
- LOAD (1 cycle), then go to EVAL:
  - Capture M<=multiplicando and Q<=multiplicador.
  - Clear A<=0 (A is N+1 bits), Q_1<=0, contador<=0.
  - Clear listo<=0.
- EVAL (1 cycle), then go to SHIFT:
  - {Q[0],Q_1}=01: A <= A + sext(M).
  - {Q[0],Q_1}=10: A <= A - sext(M).
  - {Q[0],Q_1}=00 or 11: A unchanged.
- SHIFT (1 cycle):
  - Arithmetic right shift of {A,Q,Q_1} by one; the A MSB is replicated.
  - contador <= contador+1.
  - If contador==N-1, go to DONE; otherwise go to EVAL.
- DONE (1 cycle), then go to IDLE:
  - producto <= {A[N-1:0], Q}.
  - listo <= 1.
- Width rule: A is N+1 bits so that subtracting M = -2^(N-1) cannot overflow. The product is exact for all operand pairs, including (-128)*(-128) = +16384.
- Latency:
  - With rise sampled at edge E0, producto/listo update at edge E(2N+2); that is 18 cycles for N=8.
  - ocupado is high from after E0 through E(2N+2), then low.
- start handling while busy:
  - start edges while not in IDLE are ignored.
  - start_q keeps tracking, so a button held through completion does not retrigger.
  - A new operation needs start to fall and rise again.
- Operand changes after LOAD have no effect on the running operation.
- producto keeps its last value through IDLE and LOAD of the next operation. It changes only in DONE.
- Reset mid-operation: immediate return to IDLE with all reset values; no partial product is published.
- A rise in the same cycle as DONE is ignored; the FSM is not in IDLE that cycle.

Test Plan:
- Reset, then multiplicador=3, multiplicando=5, pulse start 0->1 -> after 18 cycles producto=0x000F, listo=1, ocupado=0; estado walks 1,2,3,...,4,0.
- multiplicador=-7 (0xF9), multiplicando=6 -> producto=0xFFD6 (-42). Also 127 x -128 -> 0xC080 (-16256).
- Operands both -128 (0x80) -> producto=0x4000 (+16384), no overflow.
- Hold start high through completion and 50 more cycles -> exactly one operation. Release, then press again -> second operation; listo drops during its LOAD and rises at its DONE.
- Start at 5x5, change operands to 0x7F/0x7F at cycle 4 -> producto=0x0019.
- Assert reset=0 mid-operation at cycle 9 -> state IDLE, producto=0, listo=0, ocupado=0 immediately. Release reset with start held high -> no operation begins.

Source files
------------

// File: rtl/booth_control_if.sv
// Operand/result bundle between the input reader, the Booth sequencer and the display stage.
interface booth_control_if #(
  parameter int N = 8
);
  logic           start;
  logic [N-1:0]   multiplicador;
  logic [N-1:0]   multiplicando;
  logic [2*N-1:0] producto;
  logic           listo;
  logic           ocupado;
  logic [2:0]     estado;

  modport master (
    output start, multiplicador, multiplicando,
    input  producto, listo, ocupado, estado
  );

  modport slave (
    input  start, multiplicador, multiplicando,
    output producto, listo, ocupado, estado
  );
endinterface

// File: rtl/booth_control.sv
// Signed radix-2 Booth multiplier sequencer: one operation per start press,
// N eval/shift iterations, sticky done flag and registered 2N-bit product.
module booth_control #(
  parameter int N = 8
) (
  input  logic          CLK100MHZ,
  input  logic          reset,
  booth_control_if.slave bus
);
  localparam int CW = ($clog2(N) < 1) ? 1 : $clog2(N);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [N:0]     a_q, a_d;
  logic [N-1:0]   q_q, q_d;
  logic           q1_q, q1_d;
  logic [N-1:0]   m_q, m_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic           listo_q, listo_d;
  logic           start_q;
  logic           rise;
  logic [N:0]     m_ext;

  assign rise  = bus.start & ~start_q;
  assign m_ext = {m_q[N-1], m_q};

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      listo_q <= 1'b0;
      // Preset high so a button already pressed at reset release is not a rise.
      start_q <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      listo_q <= listo_d;
      start_q <= bus.start;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    listo_d = listo_q;
    unique case (state_q)
      IDLE: if (rise) state_d = LOAD;
      LOAD: begin
        m_d     = bus.multiplicando;
        q_d     = bus.multiplicador;
        a_d     = '0;
        q1_d    = 1'b0;
        cnt_d   = '0;
        listo_d = 1'b0;
        state_d = EVAL;
      end
      EVAL: begin
        case ({q_q[0], q1_q})
          2'b01:   a_d = a_q + m_ext;
          2'b10:   a_d = a_q - m_ext;
          default: a_d = a_q;
        endcase
        state_d = SHIFT;
      end
      SHIFT: begin
        {a_d, q_d, q1_d} = {a_q[N], a_q, q_q};
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CW'(N-1)) ? DONE : EVAL;
      end
      DONE: begin
        prod_d  = {a_q[N-1:0], q_q};
        listo_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.producto = prod_q;
  assign bus.listo    = listo_q;
  assign bus.ocupado  = (state_q != IDLE);
  assign bus.estado   = state_q;
endmodule
